// File: rtl/muldiv_unit.sv
// muldiv_unit - iterative MIPS32 multiply/divide unit producing the HI/LO pair.
//
// One shift-add (multiply) or restoring shift-subtract (divide) step per clock.
// Every operation takes the same fixed latency, whatever the operand values.
// A start accepted at edge E0 gives a one-cycle done pulse in the cycle after
// edge E(BUS_SIZE+1).
//
// Optional feature macro: MULDIV_SIGNED_EN
//   defined   : MULT/DIV (op[0]=1) use signed arithmetic.
//   undefined : op[0] is ignored, so every operation is unsigned.
//
// Ports:
//   clk   in  rising-edge clock
//   rst   in  asynchronous active-high reset
//   start in  operation request, sampled only while busy=0
//   op    in  00 MULTU, 01 MULT, 10 DIVU, 11 DIV (bit 0 = signed)
//   opA   in  multiplicand / dividend
//   opB   in  multiplier / divisor
//   hi    out product upper half / remainder
//   lo    out product lower half / quotient
//   busy  out operation in progress
//   done  out one-cycle pulse, hi/lo hold the new result
module muldiv_unit #(
  parameter int BUS_SIZE = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [BUS_SIZE-1:0] opA,
  input  logic [BUS_SIZE-1:0] opB,
  output logic [BUS_SIZE-1:0] hi,
  output logic [BUS_SIZE-1:0] lo,
  output logic                busy,
  output logic                done
);

  localparam int W  = BUS_SIZE;
  localparam int CW = $clog2(BUS_SIZE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Conditional two's-complement negation, single and double width.
  function automatic logic [W-1:0] cneg_w(input logic [W-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  function automatic logic [2*W-1:0] cneg_2w(input logic [2*W-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  state_t          state_q;
  logic [CW-1:0]   count_q;
  logic [2*W-1:0]  acc_q;     // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [W-1:0]    oper_q;    // multiplicand (mul) or divisor (div)
  logic            is_div_q;
  logic            dz_q;
  logic [W-1:0]    hi_q;
  logic [W-1:0]    lo_q;
  logic            busy_q;
  logic            done_q;
`ifdef MULDIV_SIGNED_EN
  logic            neg_q;     // product / quotient must be negated
  logic            rneg_q;    // remainder must be negated
  logic            prod_neg;
  logic            rem_neg;
`else
  logic            op_sign_unused;
  assign op_sign_unused = op[0];
`endif

  logic [W-1:0]    opa_mag;
  logic [W-1:0]    opb_mag;
  logic [W:0]      mul_sum;
  logic [W:0]      rem_sh;
  logic [W:0]      rem_diff;
  logic [2*W-1:0]  acc_d;
  logic [2*W-1:0]  prod_fix;
  logic [W-1:0]    rem_fix;
  logic [W-1:0]    quo_fix;
  logic [W-1:0]    hi_d;
  logic [W-1:0]    lo_d;

  // Operand magnitudes and result signs captured when a start is accepted.
  always_comb begin
`ifdef MULDIV_SIGNED_EN
    opa_mag  = cneg_w(opA, op[0] & opA[W-1]);
    opb_mag  = cneg_w(opB, op[0] & opB[W-1]);
    prod_neg = op[0] & (opA[W-1] ^ opB[W-1]);
    rem_neg  = op[0] & opA[W-1];
`else
    opa_mag  = opA;
    opb_mag  = opB;
`endif
  end

  // One iteration: multiply adds the multiplicand into the upper half and shifts
  // right; divide shifts the remainder left and keeps the difference only if it
  // did not borrow.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, oper_q} : {(W+1){1'b0}});
    rem_sh   = acc_q[2*W-1:W-1];
    rem_diff = rem_sh - {1'b0, oper_q};
    if (is_div_q) begin
      if (!rem_diff[W]) begin
        acc_d = {rem_diff[W-1:0], acc_q[W-2:0], 1'b1};
      end else begin
        acc_d = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
      end
    end else begin
      acc_d = {mul_sum, acc_q[W-1:1]};
    end
  end

  // Final sign correction and result selection. With a zero divisor the
  // remainder path has shifted the whole dividend magnitude in, so re-applying
  // the dividend sign reproduces the raw opA for hi.
  always_comb begin
`ifdef MULDIV_SIGNED_EN
    prod_fix = cneg_2w(acc_q, neg_q);
    quo_fix  = cneg_w(acc_q[W-1:0], neg_q);
    rem_fix  = cneg_w(acc_q[2*W-1:W], rneg_q);
`else
    prod_fix = acc_q;
    quo_fix  = acc_q[W-1:0];
    rem_fix  = acc_q[2*W-1:W];
`endif
    if (is_div_q) begin
      hi_d = rem_fix;
      lo_d = dz_q ? {W{1'b1}} : quo_fix;
    end else begin
      hi_d = prod_fix[2*W-1:W];
      lo_d = prod_fix[W-1:0];
    end
  end

  // Control FSM with registered busy/done and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= {CW{1'b0}};
      acc_q    <= {(2*W){1'b0}};
      oper_q   <= {W{1'b0}};
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= {W{1'b0}};
      lo_q     <= {W{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            is_div_q <= op[1];
            dz_q     <= (opB == {W{1'b0}});
            oper_q   <= op[1] ? opb_mag : opa_mag;
            acc_q    <= {{W{1'b0}}, (op[1] ? opa_mag : opb_mag)};
            count_q  <= CW'(W - 1);
            busy_q   <= 1'b1;
            state_q  <= CALC;
`ifdef MULDIV_SIGNED_EN
            neg_q    <= prod_neg;
            rneg_q   <= rem_neg;
`endif
          end else begin
            busy_q   <= 1'b0;
          end
        end
        CALC: begin
          acc_q   <= acc_d;
          count_q <= count_q - CW'(1);
          if (count_q == {CW{1'b0}}) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: fixed vector table, randomized operations against
// an arithmetic reference model, and hand-written latency / ignored-start /
// mid-operation reset sequences.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t tbl[$];

  muldiv_unit #(.BUS_SIZE(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .opA   (opA),
    .opB   (opB),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the MIPS rules.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] mh, output logic [31:0] ml);
    logic sgn;
    longint sa, sb, sp;
    longint unsigned ua, ub, up;
`ifdef MULDIV_SIGNED_EN
    sgn = o[0];
`else
    sgn = 1'b0;
`endif
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (!o[1]) begin
      if (sgn) begin
        sp = sa * sb;
        up = sp;
      end else begin
        up = ua * ub;
      end
      mh = up[63:32];
      ml = up[31:0];
    end else if (b == 32'd0) begin
      mh = a;
      ml = 32'hFFFF_FFFF;
    end else if (sgn) begin
      sp = sa / sb;
      ml = sp[31:0];
      sp = sa % sb;
      mh = sp[31:0];
    end else begin
      up = ua / ub;
      ml = up[31:0];
      up = ua % ub;
      mh = up[31:0];
    end
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation, then scramble the inputs while it runs. A second start
  // is pulsed poke_at cycles after acceptance (negative: never).
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el,
                       input int poke_at, input string tag);
    int lat;
    bit busy_ok;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    opA   = a;
    opB   = b;
    @(posedge clk);
    #1;
    start   = 1'b0;
    op      = 2'($urandom);
    opA     = $urandom;
    opB     = $urandom;
    lat     = 0;
    busy_ok = 1'b1;
    while (!done && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      start = (lat == poke_at);
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    check($sformatf("%s latency", tag), lat, 33);
    check($sformatf("%s busy while running", tag), {31'd0, busy_ok}, 32'd1);
    check($sformatf("%s busy at done", tag), {31'd0, busy}, 32'd0);
    check($sformatf("%s hi", tag), hi, eh);
    check($sformatf("%s lo", tag), lo, el);
  endtask

  initial begin
    logic [31:0] mh, ml;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    bit          seen;

    rst   = 1'b1;
    start = 1'b0;
    op    = 2'd0;
    opA   = 32'd0;
    opB   = 32'd0;

`ifdef MULDIV_SIGNED_EN
    tbl.push_back('{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    tbl.push_back('{2'b01, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB});
    tbl.push_back('{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
    tbl.push_back('{2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD});
    tbl.push_back('{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
    tbl.push_back('{2'b10, 32'd100,       32'd7,         32'd2,         32'd14});
    tbl.push_back('{2'b10, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF});
    tbl.push_back('{2'b11, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF});
    tbl.push_back('{2'b11, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD});
    tbl.push_back('{2'b00, 32'd0,         32'd0,         32'd0,         32'd0});
`else
    tbl.push_back('{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    tbl.push_back('{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    tbl.push_back('{2'b01, 32'hFFFF_FFFD, 32'd7,         32'd6,         32'hFFFF_FFEB});
    tbl.push_back('{2'b11, 32'hFFFF_FFF9, 32'd2,         32'd1,         32'h7FFF_FFFC});
    tbl.push_back('{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000});
    tbl.push_back('{2'b10, 32'd100,       32'd7,         32'd2,         32'd14});
    tbl.push_back('{2'b10, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF});
    tbl.push_back('{2'b11, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF});
    tbl.push_back('{2'b00, 32'd0,         32'd0,         32'd0,         32'd0});
`endif

    // Reset state.
    #12;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Fixed vectors, issued back-to-back (each start lands in the done cycle).
    foreach (tbl[i]) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp_hi, tbl[i].exp_lo, -1,
            $sformatf("vec%0d", i));
    end

    // done lasts exactly one cycle and hi/lo hold afterwards.
    @(posedge clk);
    #1;
    check("done pulse width", {31'd0, done}, 32'd0);
    check("hold hi", hi, tbl[tbl.size()-1].exp_hi);
    check("hold lo", lo, tbl[tbl.size()-1].exp_lo);

    // Randomized operations against the model.
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      model(ro, ra, rb, mh, ml);
      do_op(ro, ra, rb, mh, ml, -1, $sformatf("rand%0d op%0d %h %h", i, ro, ra, rb));
    end

    // A start pulsed 10 cycles into an operation is ignored.
    do_op(2'b00, 32'd100, 32'd7, 32'd0, 32'd700, 10, "ignored start");

    // Reset 20 cycles into an operation aborts it and clears HI/LO.
    @(negedge clk);
    start = 1'b1;
    op    = 2'b10;
    opA   = 32'd12345;
    opB   = 32'd678;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort hi", hi, 32'd0);
    check("abort lo", lo, 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1'b1;
    end
    check("no activity after abort", {31'd0, seen}, 32'd0);

    // A fresh operation after the abort completes normally.
    model(2'b10, 32'd12345, 32'd678, mh, ml);
    do_op(2'b10, 32'd12345, 32'd678, mh, ml, -1, "after reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
